// File: rtl/apb_share_arbiter.sv
// Two-port APB arbiter: shares one downstream APB completer between two
// upstream masters with round-robin grant, one transfer in flight, and a
// programmable timeout that aborts a hung downstream transfer with PSLVERR.
module apb_share_arbiter #(
    parameter int unsigned       ADDR_W         = 32,
    parameter int unsigned       DATA_W         = 32,
    parameter int unsigned       TIMEOUT_CYCLES = 1024,
    parameter logic [DATA_W-1:0] TIMEOUT_RDATA  = DATA_W'(32'hDEAD_BEEF)
) (
    input  logic              core_clk,
    input  logic              ARESETN,

    input  logic [ADDR_W-1:0] s0_paddr,
    input  logic              s0_psel,
    input  logic              s0_penable,
    input  logic              s0_pwrite,
    input  logic [DATA_W-1:0] s0_pwdata,
    input  logic [3:0]        s0_pstrb,
    input  logic [2:0]        s0_pprot,
    output logic [DATA_W-1:0] s0_prdata,
    output logic              s0_pready,
    output logic              s0_pslverr,

    input  logic [ADDR_W-1:0] s1_paddr,
    input  logic              s1_psel,
    input  logic              s1_penable,
    input  logic              s1_pwrite,
    input  logic [DATA_W-1:0] s1_pwdata,
    input  logic [3:0]        s1_pstrb,
    input  logic [2:0]        s1_pprot,
    output logic [DATA_W-1:0] s1_prdata,
    output logic              s1_pready,
    output logic              s1_pslverr,

    output logic [ADDR_W-1:0] m_paddr,
    output logic              m_psel,
    output logic              m_penable,
    output logic              m_pwrite,
    output logic [DATA_W-1:0] m_pwdata,
    output logic [3:0]        m_pstrb,
    output logic [2:0]        m_pprot,
    input  logic [DATA_W-1:0] m_prdata,
    input  logic              m_pready,
    input  logic              m_pslverr,

    output logic              grant_id,
    output logic              busy,
    output logic [7:0]        timeout_cnt
);

    localparam int unsigned     CNT_W      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic            TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    state_t            state;
    logic              last_grant;
    logic [CNT_W-1:0]  wait_cnt;
    logic [DATA_W-1:0] rdata_q;
    logic              pslverr_q;

    logic winner_c;
    logic g_psel_c;
    logic g_penable_c;
    logic resp_ready_c;
    logic timeout_hit_c;

    // Arbitration, granted-port view and the upstream completion strobe
    always_comb begin
        winner_c      = (s0_psel && s1_psel) ? ~last_grant : s1_psel;
        g_psel_c      = grant_id ? s1_psel    : s0_psel;
        g_penable_c   = grant_id ? s1_penable : s0_penable;
        resp_ready_c  = (state == ST_RESP) && g_psel_c && g_penable_c;
        timeout_hit_c = TIMEOUT_EN && (wait_cnt == CNT_LAST);
    end

    // Only the granted port ever sees pready; read data is zero outside pready
    always_comb begin
        s0_pready  = resp_ready_c && !grant_id;
        s1_pready  = resp_ready_c &&  grant_id;
        s0_prdata  = s0_pready ? rdata_q : '0;
        s1_prdata  = s1_pready ? rdata_q : '0;
        s0_pslverr = s0_pready && pslverr_q;
        s1_pslverr = s1_pready && pslverr_q;
    end

    // Transfer sequencer: grant, drive downstream, capture result, hand back
    always_ff @(posedge core_clk or negedge ARESETN) begin
        if (!ARESETN) begin
            state       <= ST_IDLE;
            last_grant  <= 1'b1;
            grant_id    <= 1'b0;
            busy        <= 1'b0;
            wait_cnt    <= '0;
            rdata_q     <= '0;
            pslverr_q   <= 1'b0;
            timeout_cnt <= '0;
            m_paddr     <= '0;
            m_psel      <= 1'b0;
            m_penable   <= 1'b0;
            m_pwrite    <= 1'b0;
            m_pwdata    <= '0;
            m_pstrb     <= '0;
            m_pprot     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (s0_psel || s1_psel) begin
                        m_paddr    <= winner_c ? s1_paddr  : s0_paddr;
                        m_pwrite   <= winner_c ? s1_pwrite : s0_pwrite;
                        m_pwdata   <= winner_c ? s1_pwdata : s0_pwdata;
                        m_pstrb    <= winner_c ? s1_pstrb  : s0_pstrb;
                        m_pprot    <= winner_c ? s1_pprot  : s0_pprot;
                        grant_id   <= winner_c;
                        last_grant <= winner_c;
                        m_psel     <= 1'b1;
                        m_penable  <= 1'b0;
                        busy       <= 1'b1;
                        state      <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    m_penable <= 1'b1;
                    wait_cnt  <= '0;
                    state     <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (m_pready) begin
                        rdata_q   <= m_prdata;
                        pslverr_q <= m_pslverr;
                        m_psel    <= 1'b0;
                        m_penable <= 1'b0;
                        state     <= ST_RESP;
                    end else if (timeout_hit_c) begin
                        rdata_q   <= TIMEOUT_RDATA;
                        pslverr_q <= 1'b1;
                        if (timeout_cnt != 8'hFF) begin
                            timeout_cnt <= timeout_cnt + 8'd1;
                        end
                        m_psel    <= 1'b0;
                        m_penable <= 1'b0;
                        state     <= ST_RESP;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    // Completion or an abandoned request both release the bus
                    if (resp_ready_c || !g_psel_c) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_share_arbiter.sv
// Directed and randomized bench for apb_share_arbiter with a memory-backed
// downstream completer and a reference memory/round-robin model.
module tb_apb_share_arbiter;

    localparam int unsigned TO = 16;

    logic        core_clk = 1'b0;
    logic        ARESETN  = 1'b0;

    logic [31:0] u_paddr   [2];
    logic        u_psel    [2];
    logic        u_penable [2];
    logic        u_pwrite  [2];
    logic [31:0] u_pwdata  [2];
    logic [3:0]  u_pstrb   [2];
    logic [2:0]  u_pprot   [2];

    logic [31:0] s0_prdata, s1_prdata;
    logic        s0_pready, s1_pready, s0_pslverr, s1_pslverr;
    logic [31:0] m_paddr, m_pwdata, m_prdata;
    logic        m_psel, m_penable, m_pwrite, m_pready, m_pslverr;
    logic [3:0]  m_pstrb;
    logic [2:0]  m_pprot;
    logic        grant_id, busy;
    logic [7:0]  timeout_cnt;

    int n_vec  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int model_last = 1;

    int          dn_wait = 0;
    logic        dn_err  = 1'b0;
    bit          dn_rand = 1'b0;
    int          dn_cnt  = 0;
    int          dn_cur_wait = 0;
    logic [31:0] mem     [logic [31:0]];
    logic [31:0] ref_mem [logic [31:0]];
    logic        s0_seen = 1'b0;

    apb_share_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TO),
                        .TIMEOUT_RDATA(32'hDEAD_BEEF)) dut (
        .core_clk(core_clk), .ARESETN(ARESETN),
        .s0_paddr(u_paddr[0]), .s0_psel(u_psel[0]), .s0_penable(u_penable[0]),
        .s0_pwrite(u_pwrite[0]), .s0_pwdata(u_pwdata[0]), .s0_pstrb(u_pstrb[0]),
        .s0_pprot(u_pprot[0]), .s0_prdata(s0_prdata), .s0_pready(s0_pready),
        .s0_pslverr(s0_pslverr),
        .s1_paddr(u_paddr[1]), .s1_psel(u_psel[1]), .s1_penable(u_penable[1]),
        .s1_pwrite(u_pwrite[1]), .s1_pwdata(u_pwdata[1]), .s1_pstrb(u_pstrb[1]),
        .s1_pprot(u_pprot[1]), .s1_prdata(s1_prdata), .s1_pready(s1_pready),
        .s1_pslverr(s1_pslverr),
        .m_paddr(m_paddr), .m_psel(m_psel), .m_penable(m_penable), .m_pwrite(m_pwrite),
        .m_pwdata(m_pwdata), .m_pstrb(m_pstrb), .m_pprot(m_pprot), .m_prdata(m_prdata),
        .m_pready(m_pready), .m_pslverr(m_pslverr),
        .grant_id(grant_id), .busy(busy), .timeout_cnt(timeout_cnt)
    );

    always #5 core_clk = ~core_clk;

    always @(posedge core_clk) cyc <= cyc + 1;

    always @(negedge core_clk) s0_seen <= s0_seen | s0_pready | (|s0_prdata);

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed no finish, expected finish within time limit");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] st);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (st[b]) r[b*8 +: 8] = nw[b*8 +: 8];
        return r;
    endfunction

    function automatic logic [31:0] mem_get(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : 32'h0;
    endfunction

    function automatic logic [31:0] ref_get(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
    endfunction

    // Downstream completer: memory backed, configurable wait states and error
    initial begin
        m_pready = 1'b0; m_prdata = '0; m_pslverr = 1'b0;
        forever begin
            @(posedge core_clk); #1;
            m_pready = 1'b0; m_prdata = '0; m_pslverr = 1'b0;
            if (m_psel && m_penable) begin
                if (dn_cnt == 0) dn_cur_wait = dn_rand ? int'($urandom_range(0, 4)) : dn_wait;
                if (dn_cnt >= dn_cur_wait) begin
                    m_pready  = 1'b1;
                    m_pslverr = dn_err;
                    if (m_pwrite) mem[m_paddr] = merge(mem_get(m_paddr), m_pwdata, m_pstrb);
                    else          m_prdata = mem_get(m_paddr);
                end
                dn_cnt++;
            end else begin
                dn_cnt = 0;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge core_clk); #1;
    endtask

    function automatic logic rdy(input int p);
        return (p == 0) ? s0_pready : s1_pready;
    endfunction

    // One upstream APB transfer; returns data, error and latency from setup cycle
    task automatic up_xfer(input int p, input logic [31:0] a, input logic w,
                           input logic [31:0] d, input logic [3:0] s, input logic [2:0] pr,
                           output logic [31:0] rd, output logic er, output int lat);
        int  start;
        int  n;
        bit  done;
        u_paddr[p] = a; u_pwrite[p] = w; u_pwdata[p] = d; u_pstrb[p] = s; u_pprot[p] = pr;
        u_psel[p] = 1'b1; u_penable[p] = 1'b0;
        start = cyc;
        tick();
        u_penable[p] = 1'b1;
        done = 1'b0; n = 0; rd = '0; er = 1'b0; lat = -1;
        while (!done && n < 200) begin
            @(negedge core_clk);
            if (rdy(p)) begin
                rd   = (p == 0) ? s0_prdata  : s1_prdata;
                er   = (p == 0) ? s0_pslverr : s1_pslverr;
                lat  = cyc - start;
                done = 1'b1;
            end
            tick();
            n++;
        end
        u_psel[p] = 1'b0; u_penable[p] = 1'b0;
        chk($sformatf("p%0d_completed", p), 64'(done), 64'(1));
    endtask

    // Both ports request in the same cycle; the round-robin pointer picks the order
    task automatic dual_read(input string tag, input logic [31:0] a0, input logic [31:0] a1);
        logic [31:0] r0, r1;
        logic        x0, x1;
        int          l0, l1;
        int          first;
        first = 1 - model_last;
        fork
            up_xfer(0, a0, 1'b0, 32'h0, 4'h0, 3'h0, r0, x0, l0);
            up_xfer(1, a1, 1'b0, 32'h0, 4'h0, 3'h0, r1, x1, l1);
        join
        chk({tag, "_rd0"}, 64'(r0), 64'(mem_get(a0)));
        chk({tag, "_rd1"}, 64'(r1), 64'(mem_get(a1)));
        chk({tag, "_lat0"}, 64'(l0), 64'((first == 0) ? 3 : 7));
        chk({tag, "_lat1"}, 64'(l1), 64'((first == 1) ? 3 : 7));
        model_last = 1 - first;
    endtask

    task automatic reset_pulse();
        ARESETN = 1'b0; tick(); ARESETN = 1'b1; tick();
        model_last = 1;
    endtask

    // Random traffic on one port within its own address window
    task automatic rand_port(input int p);
        logic [31:0] rd, a, d;
        logic        er, w;
        logic [3:0]  s;
        int          lat;
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 2)) tick();
            a = 32'h4000_0000 | (32'(p) << 12) | (32'($urandom_range(0, 7)) << 2);
            w = 1'($urandom_range(0, 1));
            d = $urandom;
            s = 4'($urandom_range(0, 15));
            up_xfer(p, a, w, d, s, 3'($urandom_range(0, 7)), rd, er, lat);
            if (w) ref_mem[a] = merge(ref_get(a), d, s);
            else   chk($sformatf("rand_p%0d_rdata", p), 64'(rd), 64'(ref_get(a)));
            chk($sformatf("rand_p%0d_err", p), 64'(er), 64'(0));
        end
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        int          n_to;

        for (int p = 0; p < 2; p++) begin
            u_paddr[p] = '0; u_psel[p] = 1'b0; u_penable[p] = 1'b0; u_pwrite[p] = 1'b0;
            u_pwdata[p] = '0; u_pstrb[p] = '0; u_pprot[p] = '0;
        end

        // Reset state
        repeat (3) @(posedge core_clk);
        @(negedge core_clk);
        chk("rst_m_psel",    64'(m_psel),      64'(0));
        chk("rst_m_penable", 64'(m_penable),   64'(0));
        chk("rst_m_paddr",   64'(m_paddr),     64'(0));
        chk("rst_s0_pready", 64'(s0_pready),   64'(0));
        chk("rst_s1_prdata", 64'(s1_prdata),   64'(0));
        chk("rst_busy",      64'(busy),        64'(0));
        chk("rst_grant",     64'(grant_id),    64'(0));
        chk("rst_tocnt",     64'(timeout_cnt), 64'(0));
        tick(); ARESETN = 1'b1; tick();

        // Single zero-wait write from s0, cycle by cycle
        u_paddr[0] = 32'h3000_0010; u_pwrite[0] = 1'b1; u_pwdata[0] = 32'hA5A5_5A5A;
        u_pstrb[0] = 4'hF; u_pprot[0] = 3'b010; u_psel[0] = 1'b1; u_penable[0] = 1'b0;
        @(negedge core_clk);
        chk("t1_c0_m_psel", 64'(m_psel), 64'(0));
        tick(); u_penable[0] = 1'b1;
        @(negedge core_clk);
        chk("t1_c1_m_psel",    64'(m_psel),    64'(1));
        chk("t1_c1_m_penable", 64'(m_penable), 64'(0));
        chk("t1_c1_m_paddr",   64'(m_paddr),   64'(32'h3000_0010));
        chk("t1_c1_m_pwdata",  64'(m_pwdata),  64'(32'hA5A5_5A5A));
        chk("t1_c1_m_pwrite",  64'(m_pwrite),  64'(1));
        chk("t1_c1_m_pstrb",   64'(m_pstrb),   64'(4'hF));
        chk("t1_c1_m_pprot",   64'(m_pprot),   64'(3'b010));
        chk("t1_c1_grant",     64'(grant_id),  64'(0));
        chk("t1_c1_busy",      64'(busy),      64'(1));
        tick();
        @(negedge core_clk);
        chk("t1_c2_m_penable", 64'(m_penable), 64'(1));
        chk("t1_c2_s0_pready", 64'(s0_pready), 64'(0));
        tick();
        @(negedge core_clk);
        chk("t1_c3_s0_pready",  64'(s0_pready),  64'(1));
        chk("t1_c3_s0_pslverr", 64'(s0_pslverr), 64'(0));
        chk("t1_c3_m_psel",     64'(m_psel),     64'(0));
        chk("t1_c3_s1_pready",  64'(s1_pready),  64'(0));
        tick(); u_psel[0] = 1'b0; u_penable[0] = 1'b0;
        tick();
        chk("t1_busy_after", 64'(busy), 64'(0));
        chk("t1_mem",        64'(mem_get(32'h3000_0010)), 64'(32'hA5A5_5A5A));

        // Simultaneous reads, then a lone s0 transfer, then simultaneous again
        reset_pulse();
        mem[32'h2000_0000] = 32'h11;
        mem[32'h2000_0004] = 32'h22;
        dual_read("rr1", 32'h2000_0000, 32'h2000_0004);
        up_xfer(0, 32'h2000_0000, 1'b0, 32'h0, 4'h0, 3'h0, rd, er, lat);
        chk("solo_s0_rd", 64'(rd), 64'(32'h11));
        model_last = 0;
        dual_read("rr2", 32'h2000_0000, 32'h2000_0004);

        // Five downstream wait states with a slave error on s1
        mem[32'h2000_0008] = 32'hCAFE_F00D;
        dn_wait = 5; dn_err = 1'b1; s0_seen = 1'b0;
        up_xfer(1, 32'h2000_0008, 1'b0, 32'h0, 4'h0, 3'h0, rd, er, lat);
        chk("ws5_rdata", 64'(rd),  64'(32'hCAFE_F00D));
        chk("ws5_err",   64'(er),  64'(1));
        chk("ws5_lat",   64'(lat), 64'(8));
        chk("ws5_s0_quiet", 64'(s0_seen), 64'(0));
        dn_err = 1'b0;

        // Timeout abort, the exact-boundary completion, then saturation
        dn_wait = 1000; n_to = 0;
        up_xfer(0, 32'h2000_000C, 1'b0, 32'h0, 4'h0, 3'h0, rd, er, lat);
        n_to++;
        chk("to_rdata", 64'(rd),  64'(32'hDEAD_BEEF));
        chk("to_err",   64'(er),  64'(1));
        chk("to_lat",   64'(lat), 64'(TO + 2));
        chk("to_cnt1",  64'(timeout_cnt), 64'(1));
        mem[32'h2000_0010] = 32'h5555_AAAA;
        dn_wait = TO - 1;
        up_xfer(1, 32'h2000_0010, 1'b0, 32'h0, 4'h0, 3'h0, rd, er, lat);
        chk("edge_rdata", 64'(rd),  64'(32'h5555_AAAA));
        chk("edge_err",   64'(er),  64'(0));
        chk("edge_lat",   64'(lat), 64'(TO + 2));
        chk("edge_cnt",   64'(timeout_cnt), 64'(n_to));
        dn_wait = TO;
        up_xfer(1, 32'h2000_0010, 1'b0, 32'h0, 4'h0, 3'h0, rd, er, lat);
        n_to++;
        chk("late_rdata", 64'(rd), 64'(32'hDEAD_BEEF));
        chk("late_cnt",   64'(timeout_cnt), 64'(n_to));
        dn_wait = 1000;
        for (int i = 0; i < 259; i++) begin
            up_xfer(i % 2, 32'h2000_0014, 1'b0, 32'h0, 4'h0, 3'h0, rd, er, lat);
            n_to++;
            chk("sat_cnt", 64'(timeout_cnt), 64'((n_to > 255) ? 255 : n_to));
        end

        // Reset in the middle of an ACCESS phase
        u_paddr[0] = 32'h2000_0000; u_pwrite[0] = 1'b0; u_psel[0] = 1'b1; u_penable[0] = 1'b0;
        tick(); u_penable[0] = 1'b1;
        tick(); tick();
        @(negedge core_clk);
        chk("mid_m_penable", 64'(m_penable), 64'(1));
        chk("mid_busy",      64'(busy),      64'(1));
        #1 ARESETN = 1'b0;
        #1;
        chk("arst_m_psel",    64'(m_psel),      64'(0));
        chk("arst_m_penable", 64'(m_penable),   64'(0));
        chk("arst_s0_pready", 64'(s0_pready),   64'(0));
        chk("arst_busy",      64'(busy),        64'(0));
        chk("arst_tocnt",     64'(timeout_cnt), 64'(0));
        u_psel[0] = 1'b0; u_penable[0] = 1'b0;
        tick(); ARESETN = 1'b1; dn_wait = 0; tick();
        model_last = 1;
        dual_read("post_rst", 32'h2000_0000, 32'h2000_0004);
        up_xfer(1, 32'h2000_0004, 1'b0, 32'h0, 4'h0, 3'h0, rd, er, lat);
        chk("post_rst_s1_rd",  64'(rd),  64'(32'h22));
        chk("post_rst_s1_lat", 64'(lat), 64'(3));

        // Randomized concurrent traffic with random downstream wait states
        dn_rand = 1'b1;
        fork
            rand_port(0);
            rand_port(1);
        join
        dn_rand = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
